// File: rtl/yrow_delta_integrator_if.sv
// ---------------------------------------------------------------------------
// yrow_delta_integrator_if
// Bundles the change-queue input, the Y-memory row read/write port and the
// EX-stage handshake of the Y-row delta integrator.
//   master : integrator view (drives chng_ready and every op_* signal)
//   slave  : environment view (change generator, Y memory, EX stage)
// Row packing: entry k = ymem_data[k*2*DATA_W +: 2*DATA_W], {real, img}.
// ---------------------------------------------------------------------------
interface yrow_delta_integrator_if #(
  parameter int DATA_W  = 24,
  parameter int ENTRIES = 5,
  parameter int ADDR_W  = 16
);
  localparam int ENT_W = 2 * DATA_W;
  localparam int ROW_W = ENTRIES * ENT_W;

  logic              chng_valid;
  logic              chng_ready;
  logic [ADDR_W-1:0] chng_row;
  logic [ADDR_W-1:0] chng_col;
  logic [DATA_W-1:0] chng_real;
  logic [DATA_W-1:0] chng_img;
  logic              filt_EN;
  logic              op_rd_req;
  logic [ADDR_W-1:0] op_y_row;
  logic [ROW_W-1:0]  ymem_data;
  logic              yMemDataReady;
  logic              op_wr_en;
  logic [ROW_W-1:0]  op_wr_data;
  logic [ENT_W-1:0]  op_yVal1;
  logic [ENT_W-1:0]  op_yVal2;
  logic              op_EX_EN;
  logic              exModDone;
  logic              op_Done;
  logic              op_colErr;

  modport master (
    input  chng_valid, chng_row, chng_col, chng_real, chng_img, filt_EN,
           ymem_data, yMemDataReady, exModDone,
    output chng_ready, op_rd_req, op_y_row, op_wr_en, op_wr_data,
           op_yVal1, op_yVal2, op_EX_EN, op_Done, op_colErr
  );

  modport slave (
    output chng_valid, chng_row, chng_col, chng_real, chng_img, filt_EN,
           ymem_data, yMemDataReady, exModDone,
    input  chng_ready, op_rd_req, op_y_row, op_wr_en, op_wr_data,
           op_yVal1, op_yVal2, op_EX_EN, op_Done, op_colErr
  );
endinterface

// File: rtl/yrow_delta_integrator.sv
// ---------------------------------------------------------------------------
// yrow_delta_integrator
// Queues admittance changes (row, col, real, img) in a small FIFO. For each
// change it reads the packed Y-memory row, adds the delta to entry col with
// signed saturation, writes the row back, then presents the old/new entry to
// the EX stage and waits for exModDone.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : yrow_delta_integrator_if.master (change queue, Y memory, EX)
// All outputs are registered.
// ---------------------------------------------------------------------------
module yrow_delta_integrator #(
  parameter int DATA_W     = 24,
  parameter int ENTRIES    = 5,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  yrow_delta_integrator_if.master  bus
);

  localparam int ENT_W  = 2 * DATA_W;
  localparam int ROW_W  = ENTRIES * ENT_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = 2 * ADDR_W + 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_UPDATE  = 3'd2,
    S_WRITE   = 3'd3,
    S_NOTIFY  = 3'd4,
    S_WAIT_EX = 3'd5
  } state_e;

  // Signed add of two DATA_W values, clamped to the DATA_W signed range.
  // Overflow shows up as disagreement between the two top bits of the
  // sign-extended sum; the top bit then tells which rail to clamp to.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      res = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      res = sum[DATA_W-1:0];
    end
    return res;
  endfunction

  state_e state_q, state_d;

  // FIFO storage and pointers
  logic [WORD_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Latched change and fetched row
  logic [ADDR_W-1:0] chg_col_q, chg_col_d;
  logic [DATA_W-1:0] chg_real_q, chg_real_d, chg_img_q, chg_img_d;
  logic [ROW_W-1:0]  row_buf_q, row_buf_d;
  logic              ex_done_q, ex_done_d;

  // Output registers
  logic              chng_ready_q, chng_ready_d;
  logic              op_rd_req_q, op_rd_req_d;
  logic [ADDR_W-1:0] op_y_row_q, op_y_row_d;
  logic              op_wr_en_q, op_wr_en_d;
  logic [ROW_W-1:0]  op_wr_data_q, op_wr_data_d;
  logic [ENT_W-1:0]  op_yval1_q, op_yval1_d, op_yval2_q, op_yval2_d;
  logic              op_ex_en_q, op_ex_en_d;
  logic              op_done_q, op_done_d;
  logic              op_col_err_q, op_col_err_d;

  logic              full_s, empty_s, push_s, pop_s, col_ok_s;
  logic [WORD_W-1:0] push_word_s, head_s;
  logic [ADDR_W-1:0] head_row_s, head_col_s;
  logic [DATA_W-1:0] head_real_s, head_img_s;
  logic [ENT_W-1:0]  old_ent_s, new_ent_s;
  logic [ROW_W-1:0]  new_row_s;

  assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_s     = (count_q == {CNT_W{1'b0}});
  // A full queue refuses the push even if a pop happens in the same cycle.
  assign push_s      = bus.chng_valid & ~full_s;
  assign pop_s       = (state_q == S_IDLE) & bus.filt_EN & ~empty_s;
  assign push_word_s = {bus.chng_row, bus.chng_col, bus.chng_real, bus.chng_img};
  assign head_s      = fifo_mem_q[rd_ptr_q];
  assign head_row_s  = head_s[2*DATA_W+ADDR_W +: ADDR_W];
  assign head_col_s  = head_s[2*DATA_W +: ADDR_W];
  assign head_real_s = head_s[DATA_W +: DATA_W];
  assign head_img_s  = head_s[0 +: DATA_W];
  assign col_ok_s    = (head_col_s < ADDR_W'(ENTRIES));

  // FIFO next-state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = push_word_s;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {WORD_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A popped change with an out-of-range column is
  // dropped in IDLE without touching memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = (pop_s && col_ok_s) ? S_FETCH : S_IDLE;
      S_FETCH:   state_d = bus.yMemDataReady ? S_UPDATE : S_FETCH;
      S_UPDATE:  state_d = S_WRITE;
      S_WRITE:   state_d = S_NOTIFY;
      S_NOTIFY:  state_d = S_WAIT_EX;
      // Leave on the registered done flag: the next pop is two cycles after
      // exModDone rather than one.
      S_WAIT_EX: state_d = ex_done_q ? S_IDLE : S_WAIT_EX;
      default:   state_d = S_IDLE;
    endcase
  end

  // Entry select and saturating update of the addressed entry.
  always_comb begin
    old_ent_s = {ENT_W{1'b0}};
    for (int k = 0; k < ENTRIES; k++) begin
      old_ent_s = old_ent_s |
                  ((chg_col_q == ADDR_W'(k)) ? row_buf_q[k*ENT_W +: ENT_W] : {ENT_W{1'b0}});
    end
    new_ent_s = {sat_add(old_ent_s[DATA_W +: DATA_W], chg_real_q),
                 sat_add(old_ent_s[0 +: DATA_W], chg_img_q)};
    new_row_s = row_buf_q;
    for (int k = 0; k < ENTRIES; k++) begin
      new_row_s[k*ENT_W +: ENT_W] = (chg_col_q == ADDR_W'(k)) ? new_ent_s
                                                              : row_buf_q[k*ENT_W +: ENT_W];
    end
  end

  // FSM output / datapath next values; outputs are registered from state_d.
  always_comb begin
    chg_col_d    = chg_col_q;
    chg_real_d   = chg_real_q;
    chg_img_d    = chg_img_q;
    op_y_row_d   = op_y_row_q;
    row_buf_d    = row_buf_q;
    op_wr_data_d = op_wr_data_q;
    op_yval1_d   = op_yval1_q;
    op_yval2_d   = op_yval2_q;
    if (pop_s && col_ok_s) begin
      chg_col_d  = head_col_s;
      chg_real_d = head_real_s;
      chg_img_d  = head_img_s;
      op_y_row_d = head_row_s;
    end else begin
      op_y_row_d = op_y_row_q;
    end
    if ((state_q == S_FETCH) && bus.yMemDataReady) begin
      row_buf_d = bus.ymem_data;
    end else begin
      row_buf_d = row_buf_q;
    end
    if (state_q == S_UPDATE) begin
      op_wr_data_d = new_row_s;
      op_yval1_d   = old_ent_s;
      op_yval2_d   = new_ent_s;
    end else begin
      op_wr_data_d = op_wr_data_q;
    end
    ex_done_d    = (state_q == S_WAIT_EX) & bus.exModDone & ~ex_done_q;
    op_rd_req_d  = (state_d == S_FETCH);
    op_wr_en_d   = (state_d == S_WRITE);
    op_ex_en_d   = (state_d == S_NOTIFY);
    op_done_d    = (state_q == S_IDLE) & empty_s;
    chng_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    op_col_err_d = op_col_err_q | (pop_s & ~col_ok_s);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_col_q    <= {ADDR_W{1'b0}};
      chg_real_q   <= {DATA_W{1'b0}};
      chg_img_q    <= {DATA_W{1'b0}};
      row_buf_q    <= {ROW_W{1'b0}};
      ex_done_q    <= 1'b0;
      chng_ready_q <= 1'b1;
      op_rd_req_q  <= 1'b0;
      op_y_row_q   <= {ADDR_W{1'b0}};
      op_wr_en_q   <= 1'b0;
      op_wr_data_q <= {ROW_W{1'b0}};
      op_yval1_q   <= {ENT_W{1'b0}};
      op_yval2_q   <= {ENT_W{1'b0}};
      op_ex_en_q   <= 1'b0;
      op_done_q    <= 1'b1;
      op_col_err_q <= 1'b0;
    end else begin
      chg_col_q    <= chg_col_d;
      chg_real_q   <= chg_real_d;
      chg_img_q    <= chg_img_d;
      row_buf_q    <= row_buf_d;
      ex_done_q    <= ex_done_d;
      chng_ready_q <= chng_ready_d;
      op_rd_req_q  <= op_rd_req_d;
      op_y_row_q   <= op_y_row_d;
      op_wr_en_q   <= op_wr_en_d;
      op_wr_data_q <= op_wr_data_d;
      op_yval1_q   <= op_yval1_d;
      op_yval2_q   <= op_yval2_d;
      op_ex_en_q   <= op_ex_en_d;
      op_done_q    <= op_done_d;
      op_col_err_q <= op_col_err_d;
    end
  end

  assign bus.chng_ready = chng_ready_q;
  assign bus.op_rd_req  = op_rd_req_q;
  assign bus.op_y_row   = op_y_row_q;
  assign bus.op_wr_en   = op_wr_en_q;
  assign bus.op_wr_data = op_wr_data_q;
  assign bus.op_yVal1   = op_yval1_q;
  assign bus.op_yVal2   = op_yval2_q;
  assign bus.op_EX_EN   = op_ex_en_q;
  assign bus.op_Done    = op_done_q;
  assign bus.op_colErr  = op_col_err_q;

endmodule

// File: tb/tb_yrow_delta_integrator.sv
// ---------------------------------------------------------------------------
// tb_yrow_delta_integrator
// Scoreboard bench: each accepted change is applied to a reference copy of
// Y memory and the expected writeback row and old/new entry pair are queued.
// A negedge monitor plays Y memory and the EX stage and pops/compares the
// queues on every op_wr_en / op_EX_EN pulse.
// ---------------------------------------------------------------------------
module tb_yrow_delta_integrator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  yrow_delta_integrator_if bus ();

  yrow_delta_integrator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [239:0] ymem      [16];
  logic [239:0] model_mem [16];

  logic [15:0]  exp_row_q [$];
  logic [239:0] exp_wr_q  [$];
  logic [47:0]  exp_v1_q  [$];
  logic [47:0]  exp_v2_q  [$];
  logic         exp_col_err = 1'b0;

  int mem_delay = 1;
  int ex_delay  = 1;
  int rd_wait = 0, ex_wait = 0;
  bit ex_outstanding = 1'b0;
  bit prev_rd = 1'b0;
  bit have_done = 1'b0;
  int rd_rises = 0, wr_pulses = 0, ex_pulses = 0;
  int rd_rise_cyc = 0, wr_cyc = 0, ex_cyc = 0, done_cyc = 0;
  int rd_run = 0, last_rd_len = 0;
  int last_push_cyc = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sat24(input logic [23:0] a, input logic [23:0] b);
    int s;
    logic [23:0] r;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 8388607)       r = 24'h7FFFFF;
    else if (s < -8388608) r = 24'h800000;
    else                   r = s[23:0];
    return r;
  endfunction

  task automatic model_apply(input logic [15:0] row, input logic [15:0] col,
                             input logic [23:0] re, input logic [23:0] im);
    logic [239:0] r;
    logic [47:0]  o, n;
    int c;
    if (col >= 16'd5) begin
      exp_col_err = 1'b1;
    end else begin
      c = int'(col);
      r = model_mem[row[3:0]];
      o = r[c*48 +: 48];
      n = {sat24(o[47:24], re), sat24(o[23:0], im)};
      r[c*48 +: 48] = n;
      model_mem[row[3:0]] = r;
      exp_row_q.push_back(row);
      exp_wr_q.push_back(r);
      exp_v1_q.push_back(o);
      exp_v2_q.push_back(n);
    end
  endtask

  task automatic set_entry(input int row, input int col, input logic [47:0] v);
    ymem[row][col*48 +: 48]      = v;
    model_mem[row][col*48 +: 48] = v;
  endtask

  task automatic push_chg(input logic [15:0] row, input logic [15:0] col,
                          input logic [23:0] re, input logic [23:0] im, input bit exp_accept);
    @(negedge clk);
    check_eq("chng_ready", bus.chng_ready, exp_accept);
    last_push_cyc  = cyc;
    bus.chng_valid = 1'b1;
    bus.chng_row   = row;
    bus.chng_col   = col;
    bus.chng_real  = re;
    bus.chng_img   = im;
    if (exp_accept) model_apply(row, col, re, im);
    @(posedge clk);
    #1;
    bus.chng_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) begin @(negedge clk); #1; end
    while (!(exp_row_q.size() == 0 && exp_v1_q.size() == 0 && bus.op_Done === 1'b1
             && !ex_outstanding) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_timeout"}, n >= 400, 1'b0);
  endtask

  // Negedge monitor: Y-memory responder, EX responder, scoreboard compare.
  initial begin
    logic [15:0]  er;
    logic [239:0] ew;
    logic [47:0]  e1, e2;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_wait = 0; ex_outstanding = 1'b0; prev_rd = 1'b0; rd_run = 0;
        bus.yMemDataReady = 1'b0; bus.exModDone = 1'b0;
      end else begin
        // Y memory
        bus.yMemDataReady = 1'b0;
        if (bus.op_rd_req) begin
          rd_wait++;
          if (rd_wait > mem_delay) begin
            bus.yMemDataReady = 1'b1;
            bus.ymem_data     = ymem[bus.op_y_row[3:0]];
          end
        end else begin
          rd_wait = 0;
        end
        if (bus.op_rd_req && !prev_rd) begin
          rd_rises++;
          rd_rise_cyc = cyc;
          check_eq("pop_while_ex_busy", ex_outstanding, 1'b0);
          if (have_done) check_eq("pop_gap_after_done", (cyc - done_cyc) >= 3, 1'b1);
        end
        if (bus.op_rd_req) rd_run++;
        else if (prev_rd) begin last_rd_len = rd_run; rd_run = 0; end
        prev_rd = bus.op_rd_req;
        if (bus.op_wr_en) begin
          wr_pulses++;
          wr_cyc = cyc;
          if (exp_row_q.size() == 0) begin
            check_eq("unexpected_wr", 1'b1, 1'b0);
          end else begin
            er = exp_row_q.pop_front();
            ew = exp_wr_q.pop_front();
            check_eq("wr_row", bus.op_y_row, er);
            check_eq("wr_data", bus.op_wr_data, ew);
          end
          ymem[bus.op_y_row[3:0]] = bus.op_wr_data;
        end
        // EX stage
        bus.exModDone = 1'b0;
        if (ex_outstanding) begin
          if (ex_wait <= 1) begin
            bus.exModDone = 1'b1; done_cyc = cyc; have_done = 1'b1; ex_outstanding = 1'b0;
          end else begin
            ex_wait--;
          end
        end
        if (bus.op_EX_EN) begin
          ex_pulses++;
          ex_cyc = cyc;
          if (exp_v1_q.size() == 0) begin
            check_eq("unexpected_ex", 1'b1, 1'b0);
          end else begin
            e1 = exp_v1_q.pop_front();
            e2 = exp_v2_q.pop_front();
            check_eq("yVal1", bus.op_yVal1, e1);
            check_eq("yVal2", bus.op_yVal2, e2);
          end
          ex_outstanding = 1'b1;
          ex_wait = ex_delay;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr, wp, ep;
    bus.chng_valid = 1'b0; bus.chng_row = 16'd0; bus.chng_col = 16'd0;
    bus.chng_real = 24'd0; bus.chng_img = 24'd0; bus.filt_EN = 1'b0;
    bus.ymem_data = 240'd0; bus.yMemDataReady = 1'b0; bus.exModDone = 1'b0;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 10; k++) begin
        ymem[r][k*24 +: 24] = 24'(r * 4096 + k * 17 + 1);
      end
      model_mem[r] = ymem[r];
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a FETCH
    mem_delay = 50;
    bus.filt_EN = 1'b1;
    @(negedge clk);
    bus.chng_valid = 1'b1; bus.chng_row = 16'd7; bus.chng_col = 16'd0;
    bus.chng_real = 24'd1; bus.chng_img = 24'd1;
    @(posedge clk); #1;
    bus.chng_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rd_req_mid_fetch", bus.op_rd_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_rd_req", bus.op_rd_req, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_delay = 1;
    @(negedge clk); #1;
    check_eq("rst_chng_ready", bus.chng_ready, 1'b1);
    check_eq("rst_rd_req", bus.op_rd_req, 1'b0);
    check_eq("rst_y_row", bus.op_y_row, 16'd0);
    check_eq("rst_wr_en", bus.op_wr_en, 1'b0);
    check_eq("rst_wr_data", bus.op_wr_data, 240'd0);
    check_eq("rst_yVal1", bus.op_yVal1, 48'd0);
    check_eq("rst_yVal2", bus.op_yVal2, 48'd0);
    check_eq("rst_EX_EN", bus.op_EX_EN, 1'b0);
    check_eq("rst_Done", bus.op_Done, 1'b1);
    check_eq("rst_colErr", bus.op_colErr, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_no_stale_fetch", bus.op_rd_req, 1'b0);

    // Single change with minimum latency
    set_entry(3, 2, 48'h000100_000020);
    push_chg(16'd3, 16'd2, 24'h000010, 24'hFFFFF0, 1'b1);
    wait_idle("single");
    check_eq("lat_pop_to_rd", rd_rise_cyc - last_push_cyc, 2);
    check_eq("lat_rd_to_wr", wr_cyc - rd_rise_cyc, 3);
    check_eq("lat_wr_to_ex", ex_cyc - wr_cyc, 1);
    check_eq("rd_len_fast", last_rd_len, 2);
    check_eq("single_yVal1", bus.op_yVal1, 48'h000100_000020);
    check_eq("single_yVal2", bus.op_yVal2, 48'h000110_000010);

    // Saturation to both rails
    set_entry(5, 4, 48'h7FFFF0_800005);
    push_chg(16'd5, 16'd4, 24'h000020, 24'hFFFFF0, 1'b1);
    wait_idle("sat1");
    check_eq("sat_hi_lo", bus.op_yVal2, 48'h7FFFFF_800000);
    set_entry(5, 0, 48'h800010_7FFFFE);
    push_chg(16'd5, 16'd0, 24'hFFFF00, 24'h000005, 1'b1);
    wait_idle("sat2");
    check_eq("sat_lo_hi", bus.op_yVal2, 48'h800000_7FFFFF);

    // Backpressure: five pushes into a four-deep queue with filt_EN low
    ex_delay = 3;
    bus.filt_EN = 1'b0;
    rr = rd_rises; wp = wr_pulses; ep = ex_pulses;
    push_chg(16'd8, 16'd1, 24'h000100, 24'h000001, 1'b1);
    push_chg(16'd8, 16'd1, 24'hFFFE00, 24'h000002, 1'b1);
    push_chg(16'd9, 16'd2, 24'h012345, 24'hFEDCBA, 1'b1);
    push_chg(16'd8, 16'd3, 24'h000007, 24'h7FFFFF, 1'b1);
    push_chg(16'd9, 16'd4, 24'h000001, 24'h000001, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("bp_no_pop_disabled", rd_rises - rr, 0);
    check_eq("bp_not_done", bus.op_Done, 1'b0);
    bus.filt_EN = 1'b1;
    wait_idle("bp");
    check_eq("bp_wr_count", wr_pulses - wp, 4);
    check_eq("bp_ex_count", ex_pulses - ep, 4);
    check_eq("bp_done", bus.op_Done, 1'b1);
    check_eq("bp_ready_after", bus.chng_ready, 1'b1);

    // Bad column followed by a good one
    ex_delay = 1;
    check_eq("colerr_before", bus.op_colErr, exp_col_err);
    rr = rd_rises; wp = wr_pulses;
    push_chg(16'd2, 16'd5, 24'h000011, 24'h000022, 1'b1);
    push_chg(16'd2, 16'd1, 24'h000033, 24'h000044, 1'b1);
    wait_idle("badcol");
    check_eq("colerr_after", bus.op_colErr, exp_col_err);
    check_eq("badcol_one_read", rd_rises - rr, 1);
    check_eq("badcol_one_write", wr_pulses - wp, 1);

    // Slow memory and slow EX, second change must wait for exModDone
    mem_delay = 7;
    ex_delay  = 10;
    rr = rd_rises; wp = wr_pulses; ep = ex_pulses;
    push_chg(16'd11, 16'd3, 24'h100000, 24'h000100, 1'b1);
    push_chg(16'd12, 16'd0, 24'hF00000, 24'hFFFF00, 1'b1);
    wait_idle("slow");
    check_eq("slow_rd_len", last_rd_len, 8);
    check_eq("slow_reads", rd_rises - rr, 2);
    check_eq("slow_writes", wr_pulses - wp, 2);
    check_eq("slow_ex", ex_pulses - ep, 2);
    check_eq("slow_done", bus.op_Done, 1'b1);
    check_eq("colerr_sticky", bus.op_colErr, exp_col_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
